// File: rtl/alu_seq_if.sv
// Request/response bundle between the control unit and alu_seq.
// The control unit holds the master side and alu_seq holds the slave side.
interface alu_seq_if #(
  parameter int XLEN = 64
);
  logic            start;
  logic [3:0]      op;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            flag;
  logic            err;

  modport master (
    output start, op, funct3, a, b,
    input  busy, done, result, flag, err
  );

  modport slave (
    input  start, op, funct3, a, b,
    output busy, done, result, flag, err
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith/shift/compare/branch ops,
// plus a fixed-latency shift-add multiplier that holds busy while it runs.
module alu_seq #(
  parameter int XLEN = 64
) (
  input logic  clock,
  input logic  reset,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(XLEN);

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_BR   = 4'd10,
    OP_MUL  = 4'd11
  } op_t;

  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_LT  = 3'b100,
    BR_GE  = 3'b101,
    BR_LTU = 3'b110,
    BR_GEU = 3'b111
  } br_t;

  state_t          state, state_n;
  logic [XLEN-1:0] result_q, result_n;
  logic            flag_q, flag_n;
  logic            err_q, err_n;
  logic            done_q, done_n;
  logic [XLEN-1:0] acc, acc_n;
  logic [XLEN-1:0] mcand, mcand_n;
  logic [XLEN-1:0] mplier, mplier_n;
  logic [SHW-1:0]  cnt, cnt_n;

  logic [XLEN:0]   diff_ext;
  logic [XLEN-1:0] diff;
  logic [SHW-1:0]  shamt;
  logic            lt_s, lt_u;
  logic [XLEN-1:0] alu_res;
  logic            alu_flag, alu_err;
  logic [XLEN-1:0] pp;

  always_comb begin
    diff_ext = {1'b0, bus.a} - {1'b0, bus.b};
    diff     = diff_ext[XLEN-1:0];
    lt_u     = diff_ext[XLEN];
    lt_s     = $signed(bus.a) < $signed(bus.b);
    shamt    = bus.b[SHW-1:0];
  end

  always_comb begin
    alu_res  = '0;
    alu_flag = 1'b0;
    alu_err  = 1'b0;
    case (bus.op)
      OP_ADD:  alu_res = bus.a + bus.b;
      OP_SUB:  alu_res = diff;
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_SLL:  alu_res = bus.a << shamt;
      OP_SRL:  alu_res = bus.a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(bus.a) >>> shamt);
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, lt_u};
      OP_BR: begin
        alu_res = diff;
        case (bus.funct3)
          BR_EQ:   alu_flag = (diff == '0);
          BR_NE:   alu_flag = (diff != '0);
          BR_LT:   alu_flag = lt_s;
          BR_GE:   alu_flag = ~lt_s;
          BR_LTU:  alu_flag = lt_u;
          BR_GEU:  alu_flag = ~lt_u;
          default: alu_err  = 1'b1;
        endcase
      end
      OP_MUL:  alu_res = '0;
      default: alu_err = 1'b1;
    endcase
  end

  // The accept edge already consumes multiplier bit 0, so the MUL state
  // needs only XLEN-1 more edges and done lands XLEN cycles after accept.
  always_comb begin
    state_n  = state;
    result_n = result_q;
    flag_n   = flag_q;
    err_n    = err_q;
    done_n   = 1'b0;
    acc_n    = acc;
    mcand_n  = mcand;
    mplier_n = mplier;
    cnt_n    = cnt;
    pp       = mplier[0] ? mcand : '0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.op == OP_MUL) begin
            state_n  = MUL;
            acc_n    = bus.b[0] ? bus.a : '0;
            mcand_n  = bus.a << 1;
            mplier_n = bus.b >> 1;
            cnt_n    = SHW'(1);
          end else begin
            result_n = alu_res;
            flag_n   = alu_flag;
            err_n    = alu_err;
            done_n   = 1'b1;
          end
        end
      end
      MUL: begin
        acc_n    = acc + pp;
        mcand_n  = mcand << 1;
        mplier_n = mplier >> 1;
        cnt_n    = cnt + SHW'(1);
        if (cnt == SHW'(XLEN - 1)) begin
          state_n  = IDLE;
          result_n = acc + pp;
          flag_n   = 1'b0;
          err_n    = 1'b0;
          done_n   = 1'b1;
          cnt_n    = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      flag_q   <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
    end else begin
      result_q <= result_n;
      flag_q   <= flag_n;
      err_q    <= err_n;
      done_q   <= done_n;
      acc      <= acc_n;
      mcand    <= mcand_n;
      mplier   <= mplier_n;
      cnt      <= cnt_n;
    end
  end

  assign bus.busy   = (state == MUL);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.flag   = flag_q;
  assign bus.err    = err_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at XLEN=64 with hand-computed expectations.
module tb_alu_seq;
  logic clock;
  logic reset;
  int unsigned n_checks;
  int unsigned n_errors;

  alu_seq_if #(.XLEN(64)) bus ();

  alu_seq #(.XLEN(64)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a request for one cycle; returns #1 after the accept edge,
  // with operands scrambled so late sampling would show up.
  task automatic issue(input logic [3:0] o, input logic [2:0] f,
                       input logic [63:0] x, input logic [63:0] y);
    @(negedge clock);
    bus.start  = 1'b1;
    bus.op     = o;
    bus.funct3 = f;
    bus.a      = x;
    bus.b      = y;
    @(posedge clock);
    #1;
    bus.start  = 1'b0;
    bus.a      = 64'h0123_4567_89AB_CDEF;
    bus.b      = 64'hFEDC_BA98_7654_3211;
  endtask

  task automatic run1(input string tag, input logic [3:0] o, input logic [2:0] f,
                      input logic [63:0] x, input logic [63:0] y,
                      input logic [63:0] res, input logic fl, input logic er);
    issue(o, f, x, y);
    check({tag, ".done"},   {63'd0, bus.done}, 64'd1);
    check({tag, ".result"}, bus.result, res);
    check({tag, ".flag"},   {63'd0, bus.flag}, {63'd0, fl});
    check({tag, ".err"},    {63'd0, bus.err},  {63'd0, er});
  endtask

  initial begin
    int unsigned cyc;
    int unsigned busy_cnt;
    int unsigned done_at;
    int unsigned done_seen;

    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.op     = 4'd0;
    bus.funct3 = 3'd0;
    bus.a      = '0;
    bus.b      = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst.result", bus.result, 64'd0);
    check("rst.done",   {63'd0, bus.done}, 64'd0);
    check("rst.busy",   {63'd0, bus.busy}, 64'd0);
    check("rst.flag",   {63'd0, bus.flag}, 64'd0);
    check("rst.err",    {63'd0, bus.err},  64'd0);
    @(negedge clock);
    reset = 1'b0;

    run1("add", 4'd0, 3'd0, 64'd45, 64'd11, 64'd56, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    check("add.done_low", {63'd0, bus.done}, 64'd0);
    check("add.hold",     bus.result, 64'd56);

    run1("sub",   4'd1,  3'b000, 64'd11, 64'd45, 64'hFFFF_FFFF_FFFF_FFDE, 1'b0, 1'b0);
    run1("beq",   4'd10, 3'b000, 64'd1,  64'd1,  64'd0, 1'b1, 1'b0);
    run1("bne",   4'd10, 3'b001, 64'd1,  64'd1,  64'd0, 1'b0, 1'b0);
    run1("bltu",  4'd10, 3'b110, 64'd1,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, 1'b0);
    run1("blt",   4'd10, 3'b100, 64'd1,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 1'b0);
    run1("bge",   4'd10, 3'b101, 64'd1,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, 1'b0);
    run1("bgeu",  4'd10, 3'b111, 64'd1,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 1'b0);

    run1("and",   4'd2, 3'd0, 64'hF0, 64'h3C, 64'h30, 1'b0, 1'b0);
    run1("or",    4'd3, 3'd0, 64'hF0, 64'h3C, 64'hFC, 1'b0, 1'b0);
    run1("xor",   4'd4, 3'd0, 64'hF0, 64'h3C, 64'hCC, 1'b0, 1'b0);
    run1("slt",   4'd8, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1'b0, 1'b0);
    run1("sltu",  4'd9, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 1'b0);
    run1("srl",   4'd6, 3'd0, 64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000, 1'b0, 1'b0);

    // MUL -3*7 with an ADD attempted mid-run that must be dropped.
    issue(4'd11, 3'd0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7);
    cyc      = 1;
    busy_cnt = 0;
    done_at  = 0;
    while (cyc <= 200 && done_at == 0) begin
      if (bus.done) begin
        done_at = cyc;
      end else begin
        if (bus.busy) busy_cnt++;
        @(negedge clock);
        if (cyc == 10) begin
          bus.start = 1'b1;
          bus.op    = 4'd0;
          bus.a     = 64'd100;
          bus.b     = 64'd100;
        end else begin
          bus.start = 1'b0;
        end
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        cyc++;
      end
    end
    check("mul.done_at",  64'(done_at),  64'd64);
    check("mul.busy_cnt", 64'(busy_cnt), 64'd63);
    check("mul.result",   bus.result, 64'hFFFF_FFFF_FFFF_FFEB);
    check("mul.busy_end", {63'd0, bus.busy}, 64'd0);
    check("mul.err",      {63'd0, bus.err},  64'd0);
    run1("add_done_cycle", 4'd0, 3'd0, 64'd3, 64'd4, 64'd7, 1'b0, 1'b0);

    // MUL 5*9 aborted by reset ten cycles after accept.
    issue(4'd11, 3'd0, 64'd5, 64'd9);
    repeat (9) @(posedge clock);
    #1;
    check("abort.busy_before", {63'd0, bus.busy}, 64'd1);
    reset = 1'b1;
    #1;
    check("abort.result", bus.result, 64'd0);
    check("abort.busy",   {63'd0, bus.busy}, 64'd0);
    check("abort.done",   {63'd0, bus.done}, 64'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset     = 1'b0;
    done_seen = 0;
    repeat (70) begin
      @(posedge clock);
      #1;
      if (bus.done) done_seen++;
    end
    check("abort.no_done", 64'(done_seen), 64'd0);
    run1("add_after_rst", 4'd0, 3'd0, 64'd2, 64'd2, 64'd4, 1'b0, 1'b0);

    run1("sra",     4'd7,  3'd0,   64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000, 1'b0, 1'b0);
    run1("sll",     4'd5,  3'd0,   64'd1, 64'd65, 64'd2, 1'b0, 1'b0);
    run1("illegal", 4'd14, 3'd0,   64'd9, 64'd3,  64'd0, 1'b0, 1'b1);
    run1("br010",   4'd10, 3'b010, 64'd9, 64'd3,  64'd6, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
